// File: rtl/riscv_lsu_pkg.sv
// Shared constants, state encoding and access-decode helpers for the data-memory LSU.
package riscv_lsu_pkg;

   // RV32I load/store size and sign encodings carried in Funct3.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Width of the BUSY-cycle timeout counter.
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   // Funct3 is a known size/sign code for the access direction.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) begin
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Natural alignment check; byte accesses are always aligned.
   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_extend
   import riscv_lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the byte and halfword lanes addressed by the low address bits.
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   // Extend the selected lane according to the load type.
   always_comb begin
      o_data = i_rdata;
      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_BU:   o_data = {24'd0, w_byte};
         F3_HU:   o_data = {16'd0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit: issues one handshaked bus transaction per memory instruction,
// stalls the core while it is in flight, and returns the extended load result.
module data_mem_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemReq,
   input  logic              MemWrite,
   input  logic [2:0]        Funct3,
   input  logic [ADDR_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              Stall,
   output logic              Misaligned,
   output logic              BusErr,
   output logic              BusValid,
   output logic              BusWe,
   output logic [ADDR_W-1:0] BusAddr,
   output logic [DATA_W-1:0] BusWData,
   output logic [3:0]        BusWStrb,
   input  logic              BusReady,
   input  logic [DATA_W-1:0] BusRData
);

   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC);

   lsu_state_e        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_strb;
   logic [2:0]        r_f3;
   logic [1:0]        r_lo;
   logic [DATA_W-1:0] r_rdata;
   logic              r_bus_err;

   logic              w_legal;
   logic              w_issue;
   logic              w_fault;
   logic              w_busy;
   logic              w_timeout;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [3:0]        w_strb;
   logic [DATA_W-1:0] w_ext;

   assign w_legal   = f3_legal(MemWrite, Funct3) && !addr_misaligned(Funct3, ALUResult[1:0]);
   assign w_issue   = (r_state == IDLE) && MemReq && w_legal;
   assign w_fault   = (r_state == IDLE) && MemReq && !w_legal;
   assign w_busy    = (r_state == BUSY);
   assign w_timeout = w_busy && !BusReady && (r_cnt == TERM_CNT);
   assign w_addr    = {ALUResult[ADDR_W-1:2], 2'b00};

   // Lane replication and byte enables for the request presented in IDLE.
   always_comb begin
      w_wdata = WriteData;
      w_strb  = 4'b0000;
      case (Funct3[1:0])
         2'b00: begin
            w_wdata = {4{WriteData[7:0]}};
            w_strb  = 4'b0001 << ALUResult[1:0];
         end
         2'b01: begin
            w_wdata = {2{WriteData[15:0]}};
            w_strb  = 4'b0011 << ALUResult[1:0];
         end
         default: begin
            w_wdata = WriteData;
            w_strb  = 4'b1111;
         end
      endcase
      if (!MemWrite) begin
         w_strb = 4'b0000;
      end
   end

   load_extend u_load_extend (
      .i_rdata   (BusRData),
      .i_addr_lo (r_lo),
      .i_funct3  (r_f3),
      .o_data    (w_ext)
   );

   // Bus outputs: live request in the IDLE issue cycle, held copies while BUSY.
   always_comb begin
      BusValid = w_issue || w_busy;
      BusWe    = w_busy ? r_we    : (w_issue && MemWrite);
      BusAddr  = w_busy ? r_addr  : w_addr;
      BusWData = w_busy ? r_wdata : w_wdata;
      BusWStrb = w_busy ? r_strb  : (w_issue ? w_strb : 4'b0000);
   end

   assign Stall      = w_issue || w_busy;
   assign Misaligned = w_fault;
   assign BusErr     = r_bus_err;
   assign ReadData   = r_rdata;

   // FSM, request capture, timeout counter and load result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_strb    <= 4'b0000;
         r_f3      <= 3'b000;
         r_lo      <= 2'b00;
         r_rdata   <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_state <= BUSY;
                  // Counter holds the index of the current BUSY cycle.
                  r_cnt   <= CNT_W'(1);
                  r_we    <= MemWrite;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_strb  <= w_strb;
                  r_f3    <= Funct3;
                  r_lo    <= ALUResult[1:0];
               end
            end
            BUSY: begin
               if (BusReady) begin
                  if (!r_we) begin
                     r_rdata <= w_ext;
                  end
                  r_state <= DONE;
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  // A failed store leaves the last load result intact.
                  if (!r_we) begin
                     r_rdata <= '0;
                  end
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               r_cnt   <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized scoreboard bench for data_mem_lsu against a byte-addressed memory model.
module tb_data_mem_lsu;

   localparam int unsigned TO = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemReq, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData, ReadData;
   logic        Stall, Misaligned, BusErr, BusValid, BusWe, BusReady;
   logic [31:0] BusAddr, BusWData, BusRData;
   logic [3:0]  BusWStrb;

   always #5 clk = ~clk;

   data_mem_lsu #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemReq     (MemReq),
      .MemWrite   (MemWrite),
      .Funct3     (Funct3),
      .ALUResult  (ALUResult),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .Stall      (Stall),
      .Misaligned (Misaligned),
      .BusErr     (BusErr),
      .BusValid   (BusValid),
      .BusWe      (BusWe),
      .BusAddr    (BusAddr),
      .BusWData   (BusWData),
      .BusWStrb   (BusWStrb),
      .BusReady   (BusReady),
      .BusRData   (BusRData)
   );

   typedef struct packed {
      logic        mis;
      logic        err;
      logic [31:0] rd;
   } ret_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } bus_t;

   ret_t        ret_q[$];
   bus_t        bus_q[$];
   ret_t        mon_r;
   bus_t        mon_b;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  ref_mem [64];
   logic [31:0] smem [16];
   logic [31:0] exp_rd;
   int          ready_after;
   int          vcnt;
   logic        rdy_nxt;

   assign BusRData = smem[BusAddr[5:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic legal(input logic we, input logic [2:0] f3, input int off);
      logic ok;
      int   size;
      ok   = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size = 1 << f3[1:0];
      return ok && (off % size == 0);
   endfunction

   // Little-endian load straight from the byte model.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off);
      int unsigned v;
      case (f3[1:0])
         2'd0:    v = 32'(ref_mem[off]);
         2'd1:    v = 32'(ref_mem[off]) + 256 * 32'(ref_mem[off+1]);
         default: v = 32'(ref_mem[off]) + 256 * 32'(ref_mem[off+1]) +
                      65536 * 32'(ref_mem[off+2]) + 16777216 * 32'(ref_mem[off+3]);
      endcase
      if (f3 == 3'b000 && v >= 128) v = v - 256;
      if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      return v;
   endfunction

   task automatic poke_word(input int widx, input logic [31:0] w);
      smem[widx] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*widx+k] = 8'(w >> (8*k));
   endtask

   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int rdy);
      int   off, size, n, exp_n;
      logic ok, tmo, done;
      ret_t r;
      bus_t b;
      off   = int'(addr[5:0]);
      size  = 1 << f3[1:0];
      ok    = legal(we, f3, off);
      tmo   = ok && (rdy > int'(TO));
      exp_n = ok ? 1 + (tmo ? int'(TO) : rdy) : 0;
      if (ok) begin
         if (!we) begin
            exp_rd = tmo ? 32'd0 : ref_load(f3, off);
         end else if (!tmo) begin
            for (int k = 0; k < size; k++) ref_mem[off+k] = 8'(wd >> (8*k));
         end
         if (!tmo) begin
            b.we    = we;
            b.addr  = addr - (addr % 4);
            b.strb  = 4'b0000;
            b.wdata = wd;
            if (we) begin
               for (int k = 0; k < size; k++) b.strb = b.strb | 4'(1 << ((off % 4) + k));
               if (size == 1) b.wdata = (wd & 32'hFF) * 32'h0101_0101;
               if (size == 2) b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            end
            bus_q.push_back(b);
         end
      end
      r.mis = !ok;
      r.err = tmo;
      r.rd  = exp_rd;
      ret_q.push_back(r);
      ready_after = rdy;
      @(posedge clk); #1;
      MemReq = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = addr; WriteData = wd;
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (!Stall) done = 1'b1;
         else n++;
      end
      chk("stall_cycles", n, exp_n);
      @(posedge clk); #1;
      MemReq = 1'b0;
   endtask

   // Slave: raises BusReady after ready_after cycles of BusValid, never in the issue cycle.
   initial begin
      BusReady = 1'b0;
      vcnt     = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !BusValid || BusReady) begin
            vcnt    = 0;
            rdy_nxt = 1'b0;
         end else begin
            vcnt++;
            rdy_nxt = (vcnt >= ready_after);
         end
         @(posedge clk); #2;
         BusReady = rdy_nxt;
      end
   end

   // Bus monitor: checks each accepted request and applies writes to slave memory.
   always @(negedge clk) begin
      if (rst_n && BusValid && BusReady) begin
         if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got request addr %h expected none", BusAddr);
         end else begin
            mon_b = bus_q.pop_front();
            chk("bus_we", 32'(BusWe), 32'(mon_b.we));
            chk("bus_addr", BusAddr, mon_b.addr);
            chk("bus_strb", 32'(BusWStrb), 32'(mon_b.strb));
            if (mon_b.we) chk("bus_wdata", BusWData, mon_b.wdata);
            chk("stall_in_handshake", 32'(Stall), 32'd1);
         end
         if (BusWe) begin
            for (int k = 0; k < 4; k++)
               if (BusWStrb[k]) smem[BusAddr[5:2]][8*k +: 8] = BusWData[8*k +: 8];
         end
      end
   end

   // Retire monitor: an instruction retires when MemReq is seen without Stall.
   always @(negedge clk) begin
      if (rst_n) begin
         if (MemReq && !Stall) begin
            if (ret_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL retire_unexpected: got retire expected none at %0t", $time);
            end else begin
               mon_r = ret_q.pop_front();
               chk("misaligned", 32'(Misaligned), 32'(mon_r.mis));
               chk("bus_err", 32'(BusErr), 32'(mon_r.err));
               chk("read_data", ReadData, mon_r.rd);
               chk("valid_at_retire", 32'(BusValid), 32'd0);
            end
         end else begin
            chk("no_spurious_flag", {30'd0, Misaligned, BusErr}, 32'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] tmp, addr, wd;
      int          off, size, rdy;
      rst_n = 1'b0; MemReq = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
      ALUResult = '0; WriteData = '0; exp_rd = '0; ready_after = 1;
      for (int w = 0; w < 16; w++) poke_word(w, $urandom());
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_read_data", ReadData, 32'd0);
      chk("rst_bus_valid", 32'(BusValid), 32'd0);
      chk("rst_bus_we", 32'(BusWe), 32'd0);
      chk("rst_bus_strb", 32'(BusWStrb), 32'd0);
      chk("rst_stall", 32'(Stall), 32'd0);
      chk("rst_flags", {30'd0, Misaligned, BusErr}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // LW with two wait states.
      poke_word(4, 32'hDEAD_BEEF);
      do_access(1'b0, 3'b010, 32'h10, 32'd0, 3);
      // LB / LBU on the top byte.
      poke_word(4, 32'h80FF_7F01);
      do_access(1'b0, 3'b000, 32'h13, 32'd0, 1);
      do_access(1'b0, 3'b100, 32'h13, 32'd0, 2);
      // SH to the upper half, then read it back.
      do_access(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 1);
      do_access(1'b0, 3'b010, 32'h20, 32'd0, 1);
      // Misaligned LW and illegal Funct3.
      do_access(1'b0, 3'b010, 32'h06, 32'd0, 1);
      do_access(1'b0, 3'b011, 32'h08, 32'd0, 1);

      // Reset during the second BUSY cycle abandons the request.
      ready_after = 1000;
      @(posedge clk); #1;
      MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h10;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0; MemReq = 1'b0;
      @(negedge clk);
      chk("valid_before_reset_edge", 32'(BusValid), 32'd1);
      @(negedge clk);
      chk("reset_mid_valid", 32'(BusValid), 32'd0);
      chk("reset_mid_stall", 32'(Stall), 32'd0);
      chk("reset_mid_read_data", ReadData, 32'd0);
      exp_rd = 32'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Load timeout with BusReady never asserted.
      do_access(1'b0, 3'b010, 32'h18, 32'd0, 1000);
      // Load after the error returns to normal service.
      do_access(1'b0, 3'b101, 32'h22, 32'd0, 1);

      for (int i = 0; i < 200; i++) begin
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         size = 1 << f3[1:0];
         off  = $urandom_range(0, 63);
         if ($urandom_range(0, 3) != 0) off = off - (off % size);
         tmp  = $urandom();
         addr = {tmp[31:6], 6'(off)};
         wd   = $urandom();
         rdy  = $urandom_range(1, 4);
         do_access(we, f3, addr, wd, rdy);
      end

      repeat (3) @(posedge clk);
      chk("ret_queue_drained", 32'(ret_q.size()), 32'd0);
      chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
